// File: rtl/video_timing_rx_if.sv
// Pixel-clock video bus as seen by the timing receiver.
// The generator side drives it and the receiver samples it.
interface video_timing_rx_if;
   logic       hs;
   logic       vs;
   logic       hblank;
   logic       vblank;
   logic       de;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;

   modport master (output hs, vs, hblank, vblank, de, r, g, b);
   modport slave  (input  hs, vs, hblank, vblank, de, r, g, b);
endinterface

// File: rtl/video_timing_rx.sv
// Video timing receiver: active x/y, frame geometry, sync polarity, lock.
// Per-frame pixel CRC-16 is built only with VIDEO_TIMING_RX_CRC_EN.
module video_timing_rx #(
   parameter int CW          = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              pclk,
   input  logic              reset,
   video_timing_rx_if.slave  vid,
   output logic [CW-1:0]     x,
   output logic [CW-1:0]     y,
   output logic [CW-1:0]     h_total,
   output logic [CW-1:0]     h_active,
   output logic [CW-1:0]     v_total,
   output logic [CW-1:0]     v_active,
   output logic              hs_pol,
   output logic              vs_pol,
   output logic              frame_done,
   output logic              locked,
   output logic              ovf,
   output logic [15:0]       crc
);
   localparam int MW = $clog2(LOCK_FRAMES + 1);
   localparam logic [MW-1:0] LF = MW'(LOCK_FRAMES);

   typedef enum logic {DISARMED, ARMED} state_t;
   state_t state, state_n;

   logic s_hs, s_vs, s_hb, s_vb, s_de;
   logic d_hb, d_vb;
   logic ls, fs, pub;

   logic [CW-1:0] hcnt, hact, hsh, hsl;
   logic [CW-1:0] vcnt, vact, vsh, vsl;
   logic [CW-1:0] h_lat, a_lat;
   logic          line_de;
   logic [MW-1:0] mc;

   logic [CW-1:0] hcnt_n, hact_n, hsh_n, hsl_n;
   logic [CW-1:0] vcnt_i, vact_i, vsh_i, vsl_i;
   logic [CW-1:0] h_lat_n, a_lat_n;
   logic [CW-1:0] x_b, x_n, y_i;
   logic          hpol_n, vpol_n, de_n, ovf_n, same;
   logic [MW-1:0] mc_n;

   function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign ls = d_hb & ~s_hb;
   assign fs = d_vb & ~s_vb;

   always_ff @(posedge pclk) begin
      if (reset) state <= DISARMED;
      else       state <= state_n;
   end

   // The first frame start after reset only arms publishing.
   always_comb begin
      state_n = state;
      pub     = 1'b0;
      unique case (state)
         DISARMED: if (fs) state_n = ARMED;
         ARMED:    pub = fs;
      endcase
   end

   // Line-start effects are folded in before frame-start effects.
   always_comb begin
      hcnt_n  = ls ? CW'(1) : inc(hcnt);
      hact_n  = ls ? CW'(1) : (s_hb ? hact : inc(hact));
      hsh_n   = ls ? CW'(s_hs) : (s_hs ? inc(hsh) : hsh);
      hsl_n   = ls ? CW'(!s_hs) : (s_hs ? hsl : inc(hsl));
      h_lat_n = ls ? hcnt : h_lat;
      a_lat_n = ls ? hact : a_lat;
      hpol_n  = ls ? (hsh < hsl) : hs_pol;
      vcnt_i  = ls ? inc(vcnt) : vcnt;
      vact_i  = (ls && !s_vb) ? inc(vact) : vact;
      vsh_i   = (ls && s_vs) ? inc(vsh) : vsh;
      vsl_i   = (ls && !s_vs) ? inc(vsl) : vsl;
      vpol_n  = fs ? (vsh_i < vsl_i) : vs_pol;
      x_b     = ls ? '0 : x;
      x_n     = s_de ? inc(x_b) : x_b;
      de_n    = ls ? s_de : (line_de | s_de);
      y_i     = (ls && line_de) ? inc(y) : y;
      ovf_n   = ovf | (&hcnt_n) | (&hact_n) | (&hsh_n) | (&hsl_n)
              | (&vcnt_i) | (&vact_i) | (&vsh_i) | (&vsl_i)
              | (&x_n) | (&y_i);
      same    = {h_lat_n, a_lat_n, vcnt_i, vact_i}
             == {h_total, h_active, v_total, v_active};
      mc_n    = same ? ((mc >= LF) ? LF : mc + 1'b1) : MW'(1);
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         s_hs       <= 1'b0;
         s_vs       <= 1'b0;
         s_hb       <= 1'b0;
         s_vb       <= 1'b0;
         s_de       <= 1'b0;
         d_hb       <= 1'b0;
         d_vb       <= 1'b0;
         hcnt       <= '0;
         hact       <= '0;
         hsh        <= '0;
         hsl        <= '0;
         vcnt       <= '0;
         vact       <= '0;
         vsh        <= '0;
         vsl        <= '0;
         h_lat      <= '0;
         a_lat      <= '0;
         line_de    <= 1'b0;
         x          <= '0;
         y          <= '0;
         h_total    <= '0;
         h_active   <= '0;
         v_total    <= '0;
         v_active   <= '0;
         hs_pol     <= 1'b0;
         vs_pol     <= 1'b0;
         frame_done <= 1'b0;
         ovf        <= 1'b0;
         mc         <= '0;
      end else begin
         s_hs       <= vid.hs;
         s_vs       <= vid.vs;
         s_hb       <= vid.hblank;
         s_vb       <= vid.vblank;
         s_de       <= vid.de;
         d_hb       <= s_hb;
         d_vb       <= s_vb;
         hcnt       <= hcnt_n;
         hact       <= hact_n;
         hsh        <= hsh_n;
         hsl        <= hsl_n;
         vcnt       <= fs ? '0 : vcnt_i;
         vact       <= fs ? '0 : vact_i;
         vsh        <= fs ? '0 : vsh_i;
         vsl        <= fs ? '0 : vsl_i;
         h_lat      <= h_lat_n;
         a_lat      <= a_lat_n;
         line_de    <= de_n;
         x          <= x_n;
         y          <= fs ? '0 : y_i;
         hs_pol     <= hpol_n;
         vs_pol     <= vpol_n;
         frame_done <= pub;
         ovf        <= ovf_n;
         if (pub) begin
            h_total  <= h_lat_n;
            h_active <= a_lat_n;
            v_total  <= vcnt_i;
            v_active <= vact_i;
            mc       <= mc_n;
         end
      end
   end

   assign locked = (mc >= LF) && !ovf;

`ifdef VIDEO_TIMING_RX_CRC_EN
   logic [23:0] s_pix;
   logic [15:0] crc_run, crc_b;

   // CRC-16-CCITT, one pixel {r,g,b} per enabled cycle, MSB first.
   function automatic logic [15:0] crc24(input logic [15:0] c,
                                         input logic [23:0] d);
      logic [15:0] v;
      v = c;
      for (int i = 23; i >= 0; i--)
         v = {v[14:0], 1'b0} ^ ((v[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return v;
   endfunction

   assign crc_b = fs ? 16'hFFFF : crc_run;

   always_ff @(posedge pclk) begin
      if (reset) begin
         s_pix   <= '0;
         crc_run <= 16'hFFFF;
         crc     <= 16'h0000;
      end else begin
         s_pix   <= {vid.r, vid.g, vid.b};
         crc_run <= s_de ? crc24(crc_b, s_pix) : crc_b;
         if (pub) crc <= crc_run;
      end
   end
`else
   logic unused_rgb;
   assign unused_rgb = ^{vid.r, vid.g, vid.b};
   assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// Randomized frame stimulus with a scoreboard of published frame geometry.
module tb_video_timing_rx;
   localparam int CW = 10;
   localparam int LF = 2;

   logic          pclk = 1'b0;
   logic          reset;
   logic [CW-1:0] x, y, h_total, h_active, v_total, v_active;
   logic          hs_pol, vs_pol, frame_done, locked, ovf;
   logic [15:0]   crc;

   video_timing_rx_if vif ();

   video_timing_rx #(.CW(CW), .LOCK_FRAMES(LF)) dut (
      .pclk       (pclk),
      .reset      (reset),
      .vid        (vif.slave),
      .x          (x),
      .y          (y),
      .h_total    (h_total),
      .h_active   (h_active),
      .v_total    (v_total),
      .v_active   (v_active),
      .hs_pol     (hs_pol),
      .vs_pol     (vs_pol),
      .frame_done (frame_done),
      .locked     (locked),
      .ovf        (ovf),
      .crc        (crc)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int ht; int ha; int vt; int va;
      bit hp; bit vp; bit lk; bit ov; int cr;
   } exp_t;

   exp_t sb[$];
   exp_t hist[$];
   exp_t pend;
   bit   armed = 1'b0;
   bit   ovf_m = 1'b0;
   int   errs = 0;
   int   checks = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_h_total"}, int'(h_total), 0);
      chk({tag, "_h_active"}, int'(h_active), 0);
      chk({tag, "_v_total"}, int'(v_total), 0);
      chk({tag, "_v_active"}, int'(v_active), 0);
      chk({tag, "_hs_pol"}, int'(hs_pol), 0);
      chk({tag, "_vs_pol"}, int'(vs_pol), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_ovf"}, int'(ovf), 0);
      chk({tag, "_crc"}, int'(crc), 0);
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] c,
                                           input logic [7:0] bt);
      logic [15:0] v;
      v = c ^ {bt, 8'h00};
      for (int k = 0; k < 8; k++)
         v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
      return v;
   endfunction

   function automatic bit same_geom(input exp_t a, input exp_t b);
      return a.ht == b.ht && a.ha == b.ha && a.vt == b.vt && a.va == b.va;
   endfunction

   // Lock means the last LF published geometries agree and no overflow.
   task automatic publish();
      exp_t e;
      e = pend;
      hist.push_back(e);
      e.ov = ovf_m;
      e.lk = 1'b0;
      if (!ovf_m && hist.size() >= LF) begin
         e.lk = 1'b1;
         for (int i = 1; i < LF; i++)
            if (!same_geom(hist[hist.size() - 1 - i], hist[hist.size() - 1]))
               e.lk = 1'b0;
      end
      sb.push_back(e);
   endtask

   always @(negedge pclk) begin : monitor
      exp_t e;
      if (frame_done) begin
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL frame_done: got pulse expected none at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("h_total", int'(h_total), e.ht);
            chk("h_active", int'(h_active), e.ha);
            chk("v_total", int'(v_total), e.vt);
            chk("v_active", int'(v_active), e.va);
            chk("hs_pol", int'(hs_pol), int'(e.hp));
            chk("vs_pol", int'(vs_pol), int'(e.vp));
            chk("locked", int'(locked), int'(e.lk));
            chk("ovf", int'(ovf), int'(e.ov));
            chk("crc", int'(crc), e.cr);
         end
      end
   end

   // pm: 0 zero pixels, 1 checkerboard, 2 random.
   // longl: line index held active for 1100 cycles; rstl: line with reset.
   task automatic frame(input int ht, input int ha, input int vt, input int va,
                        input int hlo, input bit hinv, input int pm,
                        input int longl, input int rstl);
      logic [15:0] cr;
      logic [23:0] px;
      bit          clean;
      int          hhi, vhi, len, act;
      cr    = 16'hFFFF;
      clean = (longl < 0) && (rstl < 0);
      hhi   = 0;
      vhi   = 0;
      if (armed) publish();
      else armed = 1'b1;
      for (int l = 0; l < vt; l++) begin
         len = (l == longl) ? 1100 + (ht - ha) : ht;
         act = (l == longl) ? 1100 : ha;
         hhi = 0;
         for (int c = 0; c < len; c++) begin
            @(posedge pclk);
            #1;
            vif.hblank = (c >= act);
            vif.vblank = (l >= va);
            vif.de     = (c < act) && (l < va);
            vif.hs     = ((c > act) && (c <= act + hlo)) ? hinv : !hinv;
            vif.vs     = !((l > va) && (l <= va + 2));
            case (pm)
               0:       px = 24'h0;
               1:       px = ((l ^ c) & 1) != 0 ? 24'hFFFFFF : 24'h0;
               default: px = 24'($urandom);
            endcase
            {vif.r, vif.g, vif.b} = px;
            if (vif.de)
               cr = crc_ref(crc_ref(crc_ref(cr, px[23:16]), px[15:8]), px[7:0]);
            if (vif.hs) hhi++;
            if (c == 0 && vif.vs) vhi++;
            reset = (l == rstl) && (c >= 10) && (c < 13);
            if (l == rstl && c == 10) begin
               armed = 1'b0;
               ovf_m = 1'b0;
               hist.delete();
            end
            @(negedge pclk);
            if (clean && c == 1 && l > 0) begin
               chk("x_line_end", int'(x), (l - 1 < va) ? ha : 0);
               chk("y_before_ls", int'(y), (l - 1 < va) ? l - 1 : va);
            end
            if (clean && c == 2) begin
               chk("x_after_ls", int'(x), (l < va) ? 1 : 0);
               chk("y_after_ls", int'(y), (l < va) ? l : va);
            end
            if (l == rstl && c == 12) chk_zero("mid_reset");
         end
      end
      if (longl >= 0) ovf_m = 1'b1;
      pend.ht = ht;
      pend.ha = ha;
      pend.vt = vt;
      pend.va = va;
      pend.hp = hhi < (ht - hhi);
      pend.vp = vhi < (vt - vhi);
      pend.lk = 1'b0;
      pend.ov = 1'b0;
`ifdef VIDEO_TIMING_RX_CRC_EN
      pend.cr = int'(cr);
`else
      pend.cr = 0;
`endif
   endtask

   task automatic frame_a(input bit hinv, input int pm,
                          input int longl, input int rstl);
      frame(40, 24, 16, 10, 3, hinv, pm, longl, rstl);
   endtask

   initial begin
      int ht, ha, vt, va;
      reset      = 1'b1;
      vif.hblank = 1'b1;
      vif.vblank = 1'b1;
      vif.hs     = 1'b1;
      vif.vs     = 1'b1;
      vif.de     = 1'b0;
      vif.r      = '0;
      vif.g      = '0;
      vif.b      = '0;
      @(negedge pclk);
      chk_zero("reset");
      repeat (2) @(posedge pclk);
      #1 reset = 1'b0;
      repeat (4) @(posedge pclk);

      frame_a(0, 0, -1, -1);
      frame_a(0, 0, -1, -1);
      frame_a(0, 1, -1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(1, 2, -1, -1);
      frame_a(0, 2, -1, -1);
      frame(42, 24, 16, 10, 3, 0, 2, -1, -1);
      frame(42, 24, 16, 10, 3, 0, 1, -1, -1);
      frame(42, 24, 16, 10, 3, 0, 2, -1, -1);
      for (int k = 0; k < 3; k++) begin
         ht = $urandom_range(30, 48);
         ha = $urandom_range(14, ht - 6);
         vt = $urandom_range(10, 18);
         va = $urandom_range(4, vt - 4);
         frame(ht, ha, vt, va, $urandom_range(2, 4),
               1'($urandom_range(0, 1)), 2, -1, -1);
      end
      frame_a(0, 2, -1, 3);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, 1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, -1, 2);
      frame_a(0, 0, -1, -1);
      frame_a(0, 1, -1, -1);
      frame_a(0, 2, -1, -1);
      frame_a(0, 2, -1, -1);

      repeat (10) @(posedge pclk);
      @(negedge pclk);
      checks++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL pending_publishes: got %0d left expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
